// File: rtl/rca_sub_51bit_seq.sv
// Multi-cycle subtractor that recovers the unknown addend of a ripple-carry add:
// o_add_term2 = i_result - i_add_term1, CHUNK bits per clock with a registered borrow.
module rca_sub_51bit_seq #(
  parameter int WIDTH = 51,
  parameter int CHUNK = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH:0]   i_result,
  input  logic [WIDTH-1:0] i_add_term1,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_add_term2,
  output logic             o_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("rca_sub_51bit_seq: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] t_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] r_chunk;
  logic [CHUNK-1:0] t_chunk;
  logic [CHUNK-1:0] diff_chunk;
  logic [CHUNK:0]   borrow_chain;
  logic             last_chunk;

  always_comb begin
    r_chunk = '0;
    t_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        r_chunk = r_q[k*CHUNK +: CHUNK];
        t_chunk = t_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // Bit-serial ripple borrow through the selected chunk, seeded by the stored borrow.
  always_comb begin
    diff_chunk      = '0;
    borrow_chain    = '0;
    borrow_chain[0] = borrow_q;
    for (int i = 0; i < CHUNK; i++) begin
      diff_chunk[i]     = r_chunk[i] ^ t_chunk[i] ^ borrow_chain[i];
      borrow_chain[i+1] = (~r_chunk[i] & t_chunk[i]) |
                          (~(r_chunk[i] ^ t_chunk[i]) & borrow_chain[i]);
    end
  end

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_ready     <= 1'b0;
      o_valid     <= 1'b0;
      o_add_term2 <= '0;
      o_err       <= 1'b0;
      r_q         <= '0;
      t_q         <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_valid && o_ready) begin
            r_q      <= i_result;
            t_q      <= i_add_term1;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            o_ready  <= 1'b0;
            state    <= RUN;
          end else begin
            o_ready <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
              o_add_term2[k*CHUNK +: CHUNK] <= diff_chunk;
            end
          end
          borrow_q <= borrow_chain[CHUNK];
          cnt_q    <= cnt_q + CW'(1);
          // The carry-in bit of the result absorbs (or fails to absorb) the final borrow.
          if (last_chunk) begin
            o_err   <= r_q[WIDTH] ^ borrow_chain[CHUNK];
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_sub_51bit_seq.sv
// Self-checking bench for rca_sub_51bit_seq: directed vector table, random pairs
// against an arithmetic reference model, backpressure and mid-run reset sequences.
module tb_rca_sub_51bit_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [51:0] i_result;
  logic [50:0] i_add_term1;
  logic        o_valid;
  logic        i_ready;
  logic [50:0] o_add_term2;
  logic        o_err;

  int checks;
  int failures;

  typedef struct {
    logic [51:0] r;
    logic [50:0] t;
    logic [50:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[8];

  rca_sub_51bit_seq dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_result   (i_result),
    .i_add_term1(i_add_term1),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_add_term2(o_add_term2),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Difference taken in 53 bits: a negative or >= 2^51 result means no 51-bit addend.
  function automatic void model(input logic [51:0] r, input logic [50:0] t,
                                output logic [50:0] d, output logic e);
    logic [52:0] full;
    full = {1'b0, r} - {2'b00, t};
    d    = full[50:0];
    e    = full[52] | full[51];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    checkOutput({name, "_ready_wait"}, 64'(o_ready), 64'd1);
  endtask

  task automatic applyStimulus(input logic [51:0] r, input logic [50:0] t,
                               input logic [50:0] exp_d, input logic exp_e,
                               input int hold, input bit inject, input string name);
    int  n;
    bit  ready_seen;
    wait_ready(name);
    i_result    = r;
    i_add_term1 = t;
    i_valid     = 1'b1;
    i_ready     = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    if (inject) begin
      i_result    = ~r;
      i_add_term1 = ~t;
      i_valid     = 1'b1;
    end
    n = 0;
    ready_seen = 1'b0;
    while (!o_valid && n < 10) begin
      if (o_ready) ready_seen = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      n++;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'd3);
    checkOutput({name, "_ready_low"}, 64'(ready_seen | o_ready), 64'd0);
    checkOutput({name, "_term2"}, 64'(o_add_term2), 64'(exp_d));
    checkOutput({name, "_err"}, 64'(o_err), 64'(exp_e));
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      checkOutput({name, "_hold_valid"}, 64'(o_valid), 64'd1);
      checkOutput({name, "_hold_ready"}, 64'(o_ready), 64'd0);
      checkOutput({name, "_hold_term2"}, 64'(o_add_term2), 64'(exp_d));
      checkOutput({name, "_hold_err"}, 64'(o_err), 64'(exp_e));
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    checkOutput({name, "_release_valid"}, 64'(o_valid), 64'd0);
    checkOutput({name, "_release_ready"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [50:0] a;
    logic [50:0] b;
    logic [50:0] md;
    logic        me;

    checks      = 0;
    failures    = 0;
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_ready     = 1'b0;
    i_result    = '0;
    i_add_term1 = '0;

    vecs[0] = '{52'h0C, 51'h05, 51'h07, 1'b0};
    vecs[1] = '{52'h20000, 51'h1, 51'h1FFFF, 1'b0};
    vecs[2] = '{52'hF_FFFF_FFFF_FFFE, 51'h7_FFFF_FFFF_FFFF, 51'h7_FFFF_FFFF_FFFF, 1'b0};
    vecs[3] = '{52'h3, 51'h5, 51'h7_FFFF_FFFF_FFFE, 1'b1};
    vecs[4] = '{52'h8_0000_0000_0000, 51'h0, 51'h0, 1'b1};
    vecs[5] = '{52'h0, 51'h0, 51'h0, 1'b0};
    vecs[6] = '{52'h7_FFFF_FFFF_FFFF, 51'h7_FFFF_FFFF_FFFF, 51'h0, 1'b0};
    vecs[7] = '{52'h4_0000_0000, 51'h1, 51'h3_FFFF_FFFF, 1'b0};

    #2;
    checkOutput("reset_ready", 64'(o_ready), 64'd0);
    checkOutput("reset_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_term2", 64'(o_add_term2), 64'd0);
    checkOutput("reset_err", 64'(o_err), 64'd0);
    #10;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("first_edge_ready", 64'(o_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].r, vecs[i].t, vecs[i].exp_d, vecs[i].exp_e, 0, 1'b0,
                    $sformatf("vec%0d", i));
    end

    // Random addend pairs must always round-trip without error.
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      a  = ra[50:0];
      b  = rb[50:0];
      applyStimulus({1'b0, a} + {1'b0, b}, a, b, 1'b0, 0, 1'b0, $sformatf("pair%0d", i));
    end

    // Unconstrained operands, including the error cases, against the model.
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      model(ra[51:0], rb[50:0], md, me);
      applyStimulus(ra[51:0], rb[50:0], md, me, 0, 1'b0, $sformatf("rand%0d", i));
    end

    applyStimulus(52'h1234_5678_9ABC, 51'h0765_4321_0FED, 51'h0ACF_1357_8ACF, 1'b0,
                  5, 1'b1, "backpressure");

    wait_ready("rst_mid");
    i_result    = 52'h0C;
    i_add_term1 = 51'h05;
    i_valid     = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_mid_err", 64'(o_err), 64'd0);
    checkOutput("rst_mid_term2", 64'(o_add_term2), 64'd0);
    checkOutput("rst_mid_ready", 64'(o_ready), 64'd0);
    #5;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("rst_release_ready", 64'(o_ready), 64'd1);
    applyStimulus(52'h0C, 51'h05, 51'h07, 1'b0, 0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
